// File: rtl/fp_add_v1_pkg.sv
// -----------------------------------------------------------------------------
// fp_add_v1_pkg
// Shared definitions for the fp_add_v1 adder datapath:
//   - default widths of the mantissa sum, biased exponent and shift count
//   - the all-ones exponent (infinity / NaN encoding) for the default width
//   - bit indices of the guard / round / sticky bits in the mantissa sum
//   - the packed exception-flag vector produced by the normalize stage
// -----------------------------------------------------------------------------
package fp_add_v1_pkg;

    localparam int FP_MANT_W = 28;
    localparam int FP_EXP_W  = 8;
    localparam int FP_LZC_W  = 5;

    localparam logic [FP_EXP_W-1:0] EXP_MAX = {FP_EXP_W{1'b1}};

    // Guard/round/sticky occupy the three least significant mantissa bits.
    localparam int FP_GUARD_IDX  = 2;
    localparam int FP_ROUND_IDX  = 1;
    localparam int FP_STICKY_IDX = 0;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic unf;
    } fp_flags_t;

endpackage : fp_add_v1_pkg

// File: rtl/fp_add_v1_norm_lzc.sv
// -----------------------------------------------------------------------------
// fp_add_v1_norm_lzc
// Combinational leading-zero counter built as a tree of altpriority-encoder
// style merge cells. The input is left-aligned into a 2**LZC_W wide vector
// (zero padded at the bottom, which never changes the count of a non-zero
// input). Each tree level merges neighbouring pairs: the upper half wins if it
// holds a one, otherwise the lower half's count is used with the level's
// weight bit set.
//
// Ports:
//   i_vec   in   IN_W    vector to scan, counted from bit IN_W-1 downwards
//   o_lzc   out  LZC_W   number of leading zeros; IN_W when i_vec is zero
//   o_zero  out  1       i_vec is all zero
// -----------------------------------------------------------------------------
module fp_add_v1_norm_lzc #(
    parameter int IN_W  = 27,
    parameter int LZC_W = 5
) (
    input  logic [IN_W-1:0]  i_vec,
    output logic [LZC_W-1:0] o_lzc,
    output logic             o_zero
);

    localparam int P   = 2 ** LZC_W;
    localparam int PAD = P - IN_W;

    logic [P-1:0]     w_pad;
    logic             w_v   [LZC_W+1][P];
    logic [LZC_W-1:0] w_cnt [LZC_W+1][P];

    assign w_pad = P'(i_vec) << PAD;

    // Merge cell: hi/lo are the two child nodes, weight is this level's bit.
    function automatic logic [LZC_W-1:0] f_pe_merge(
        input logic             v_hi,
        input logic [LZC_W-1:0] c_hi,
        input logic [LZC_W-1:0] c_lo,
        input int               level
    );
        f_pe_merge = v_hi ? c_hi : (c_lo | (LZC_W'(1) << (level - 1)));
    endfunction

    always_comb begin
        for (int l = 0; l <= LZC_W; l++) begin
            for (int n = 0; n < P; n++) begin
                w_v[l][n]   = 1'b0;
                w_cnt[l][n] = '0;
            end
        end
        // Leaf n corresponds to bit P-1-n, so node 0 is always the MSB side.
        for (int n = 0; n < P; n++) begin
            w_v[0][n] = w_pad[P-1-n];
        end
        for (int l = 1; l <= LZC_W; l++) begin
            for (int n = 0; n < (P >> l); n++) begin
                w_v[l][n]   = w_v[l-1][2*n] | w_v[l-1][2*n+1];
                w_cnt[l][n] = f_pe_merge(w_v[l-1][2*n], w_cnt[l-1][2*n],
                                         w_cnt[l-1][2*n+1], l);
            end
        end
    end

    assign o_zero = ~w_v[LZC_W][0];
    assign o_lzc  = o_zero ? LZC_W'(IN_W) : w_cnt[LZC_W][0];

endmodule : fp_add_v1_norm_lzc

// File: rtl/fp_add_v1_normalize_stage.sv
// -----------------------------------------------------------------------------
// fp_add_v1_normalize_stage
// Post-addition normalization for the fp_add_v1 datapath. Takes the raw
// mantissa sum (carry-out, hidden bit, fraction, GRS) and produces a
// normalized mantissa with hidden bit at MANT_W-2 plus the adjusted exponent.
// Carry-out sums shift right by one with sticky folding; others shift left by
// their leading-zero count. Exponent overflow saturates to the infinity
// encoding, underflow flushes to zero (no denormals).
// Three register stages, one result per enabled cycle, stalled by clk_en.
//
// Ports:
//   clock      in   1         clock, rising edge
//   sclr       in   1         synchronous active-high clear (overrides clk_en)
//   clk_en     in   1         pipeline enable; low holds every register
//   valid_in   in   1         operand valid
//   sign_in    in   1         result sign from the add stage
//   exp_in     in   EXP_W     biased exponent of the larger operand
//   mant_in    in   MANT_W    raw unsigned mantissa sum
//   valid_out  out  1         result valid
//   sign_out   out  1         sign, passed through
//   exp_out    out  EXP_W     adjusted biased exponent
//   mant_out   out  MANT_W-1  normalized mantissa
//   zero_out   out  1         mantissa sum was exactly zero
//   ovf_out    out  1         exponent overflow (infinity encoding)
//   unf_out    out  1         exponent underflow (flushed to zero)
// -----------------------------------------------------------------------------
module fp_add_v1_normalize_stage
    import fp_add_v1_pkg::*;
#(
    parameter int MANT_W = FP_MANT_W,
    parameter int EXP_W  = FP_EXP_W,
    parameter int LZC_W  = FP_LZC_W
) (
    input  logic              clock,
    input  logic              sclr,
    input  logic              clk_en,
    input  logic              valid_in,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic              valid_out,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-2:0] mant_out,
    output logic              zero_out,
    output logic              ovf_out,
    output logic              unf_out
);

    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-2:0] mant;
        fp_flags_t         flags;
    } norm_t;

    localparam logic signed [EXP_W+1:0] L_ONE  = {{(EXP_W+1){1'b0}}, 1'b1};
    localparam logic signed [EXP_W+1:0] L_ZERO = '0;
    localparam logic signed [EXP_W+1:0] L_EMAX = {2'b00, {EXP_W{1'b1}}};

    // Final normalization: priority zero > carry > left shift.
    function automatic norm_t f_normalize(
        input logic              zero,
        input logic              carry,
        input logic [LZC_W-1:0]  lzc,
        input logic [EXP_W-1:0]  exp,
        input logic [MANT_W-2:0] mant
    );
        logic signed [EXP_W+1:0] e;
        norm_t                   r;
        r = '0;
        e = '0;
        if (zero) begin
            r.flags.zero = 1'b1;
        end else if (carry) begin
            e = $signed({2'b00, exp}) + L_ONE;
            if (e >= L_EMAX) begin
                r.flags.ovf = 1'b1;
                r.exp       = {EXP_W{1'b1}};
            end else begin
                r.exp  = e[EXP_W-1:0];
                // Right shift by one, folding the dropped bit into sticky.
                r.mant = {carry, mant[MANT_W-2:FP_GUARD_IDX],
                          mant[FP_ROUND_IDX] | mant[FP_STICKY_IDX]};
            end
        end else begin
            e = $signed({2'b00, exp}) - $signed({{(EXP_W+2-LZC_W){1'b0}}, lzc});
            if (e <= L_ZERO) begin
                r.flags.unf = 1'b1;
            end else begin
                r.exp  = e[EXP_W-1:0];
                r.mant = mant << lzc;
            end
        end
        return r;
    endfunction

    logic              r_vld_p0;
    logic              r_sign_p0;
    logic [EXP_W-1:0]  r_exp_p0;
    logic [MANT_W-1:0] r_mant_p0;

    logic              r_vld_p1;
    logic              r_sign_p1;
    logic [EXP_W-1:0]  r_exp_p1;
    logic [MANT_W-2:0] r_mant_p1;
    logic              r_carry_p1;
    logic              r_zero_p1;
    logic [LZC_W-1:0]  r_lzc_p1;

    logic              r_vld_p2;
    logic              r_sign_p2;
    norm_t             r_res_p2;

    logic [LZC_W-1:0]  w_lzc;
    logic              w_lz_zero;
    norm_t             w_res;

    fp_add_v1_norm_lzc #(
        .IN_W  (MANT_W - 1),
        .LZC_W (LZC_W)
    ) u_lzc (
        .i_vec  (r_mant_p0[MANT_W-2:0]),
        .o_lzc  (w_lzc),
        .o_zero (w_lz_zero)
    );

    assign w_res = f_normalize(r_zero_p1, r_carry_p1, r_lzc_p1, r_exp_p1, r_mant_p1);

    // ---- S1: input capture ----
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_vld_p0  <= 1'b0;
            r_sign_p0 <= 1'b0;
            r_exp_p0  <= '0;
            r_mant_p0 <= '0;
        end else if (clk_en) begin
            r_vld_p0  <= valid_in;
            r_sign_p0 <= sign_in;
            r_exp_p0  <= exp_in;
            r_mant_p0 <= mant_in;
        end
    end

    // ---- S2: carry, leading-zero count, zero detect ----
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_vld_p1   <= 1'b0;
            r_sign_p1  <= 1'b0;
            r_exp_p1   <= '0;
            r_mant_p1  <= '0;
            r_carry_p1 <= 1'b0;
            r_zero_p1  <= 1'b0;
            r_lzc_p1   <= '0;
        end else if (clk_en) begin
            r_vld_p1   <= r_vld_p0;
            r_sign_p1  <= r_sign_p0;
            r_exp_p1   <= r_exp_p0;
            r_mant_p1  <= r_mant_p0[MANT_W-2:0];
            r_carry_p1 <= r_mant_p0[MANT_W-1];
            r_zero_p1  <= w_lz_zero & ~r_mant_p0[MANT_W-1];
            r_lzc_p1   <= w_lzc;
        end
    end

    // ---- S3: shift, exponent adjust, exception flags ----
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_vld_p2  <= 1'b0;
            r_sign_p2 <= 1'b0;
            r_res_p2  <= '0;
        end else if (clk_en) begin
            r_vld_p2  <= r_vld_p1;
            r_sign_p2 <= r_sign_p1;
            r_res_p2  <= w_res;
        end
    end

    assign valid_out = r_vld_p2;
    assign sign_out  = r_sign_p2;
    assign exp_out   = r_res_p2.exp;
    assign mant_out  = r_res_p2.mant;
    assign zero_out  = r_res_p2.flags.zero;
    assign ovf_out   = r_res_p2.flags.ovf;
    assign unf_out   = r_res_p2.flags.unf;

endmodule : fp_add_v1_normalize_stage

// File: tb/tb_fp_add_v1_normalize_stage.sv
// -----------------------------------------------------------------------------
// tb_fp_add_v1_normalize_stage
// Scoreboard bench: the driver pushes the reference-model result for every
// accepted operand; a monitor pops and compares on every enabled edge where
// valid_out is high, and checks that outputs hold across stalled edges.
// -----------------------------------------------------------------------------
module tb_fp_add_v1_normalize_stage;

    localparam int MANT_W = 28;
    localparam int EXP_W  = 8;
    localparam int LZC_W  = 5;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-2:0] mant;
        logic              zero;
        logic              ovf;
        logic              unf;
    } res_t;

    logic              clock;
    logic              sclr;
    logic              clk_en;
    logic              valid_in;
    logic              sign_in;
    logic [EXP_W-1:0]  exp_in;
    logic [MANT_W-1:0] mant_in;
    logic              valid_out;
    logic              sign_out;
    logic [EXP_W-1:0]  exp_out;
    logic [MANT_W-2:0] mant_out;
    logic              zero_out;
    logic              ovf_out;
    logic              unf_out;

    res_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    fp_add_v1_normalize_stage #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W),
        .LZC_W  (LZC_W)
    ) dut (
        .clock     (clock),
        .sclr      (sclr),
        .clk_en    (clk_en),
        .valid_in  (valid_in),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .valid_out (valid_out),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .mant_out  (mant_out),
        .zero_out  (zero_out),
        .ovf_out   (ovf_out),
        .unf_out   (unf_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic res_t dut_res();
        return {sign_out, exp_out, mant_out, zero_out, ovf_out, unf_out};
    endfunction

    // Reference: the value is renormalized so its leading one sits at the
    // hidden-bit position, and the exponent moves by the same number of places.
    function automatic res_t model(input logic s, input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
        res_t        r;
        int          ex;
        int          sh;
        logic [MANT_W-1:0] t;
        r      = '0;
        r.sign = s;
        if (m == 0) begin
            r.zero = 1'b1;
        end else if (m >= (1 << (MANT_W-1))) begin
            ex = int'(e) + 1;
            if (ex >= (1 << EXP_W) - 1) begin
                r.ovf = 1'b1;
                r.exp = {EXP_W{1'b1}};
            end else begin
                t      = (m >> 1) | (m & 1);
                r.exp  = ex[EXP_W-1:0];
                r.mant = t[MANT_W-2:0];
            end
        end else begin
            t  = m;
            sh = 0;
            while (t < (1 << (MANT_W-2))) begin
                t  = t * 2;
                sh = sh + 1;
            end
            ex = int'(e) - sh;
            if (ex <= 0) begin
                r.unf = 1'b1;
            end else begin
                r.exp  = ex[EXP_W-1:0];
                r.mant = t[MANT_W-2:0];
            end
        end
        return r;
    endfunction

    // Monitor: compares on enabled edges, checks hold on stalled edges.
    always @(posedge clock) begin : monitor
        logic en_s;
        logic rst_s;
        res_t cur;
        res_t want;
        logic [39:0] prev;
        en_s  = clk_en;
        rst_s = sclr;
        #1;
        cur = dut_res();
        if (rst_s !== 1'b1) begin
            if (en_s === 1'b1) begin
                if (valid_out === 1'b1) begin
                    check("result_pending", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        want = exp_q.pop_front();
                        check("result", 64'(cur), 64'(want));
                    end
                end
            end else begin
                check("stall_hold", 64'({valid_out, cur}), 64'(prev));
            end
        end
        prev = {valid_out, cur};
    end

    task automatic drive(input bit v, input bit en, input bit s,
                         input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
        @(negedge clock);
        sclr     = 1'b0;
        valid_in = v;
        clk_en   = en;
        sign_in  = s;
        exp_in   = e;
        mant_in  = m;
        if (v && en) exp_q.push_back(model(s, e, m));
    endtask

    task automatic do_reset(input bit en);
        @(negedge clock);
        sclr     = 1'b1;
        clk_en   = en;
        valid_in = 1'b1;
        mant_in  = MANT_W'($urandom);
        @(negedge clock);
        sclr     = 1'b0;
        clk_en   = 1'b0;
        valid_in = 1'b0;
        exp_q.delete();
        check("reset_outputs", 64'({valid_out, dut_res()}), 64'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    function automatic logic [MANT_W-1:0] rand_mant();
        logic [MANT_W-1:0] r;
        r = MANT_W'($urandom);
        if ($urandom_range(0, 9) == 0) return '0;
        return r >> $urandom_range(0, MANT_W);
    endfunction

    function automatic logic [EXP_W-1:0] rand_exp();
        case ($urandom_range(0, 3))
            0:       return EXP_W'($urandom_range(0, 30));
            1:       return EXP_W'($urandom_range(225, 255));
            default: return EXP_W'($urandom);
        endcase
    endfunction

    initial begin
        sclr     = 1'b0;
        clk_en   = 1'b0;
        valid_in = 1'b0;
        sign_in  = 1'b0;
        exp_in   = '0;
        mant_in  = '0;

        // Reset with clk_en low must still clear everything.
        do_reset(1'b0);
        idle(4);

        // Directed cases, including exponent boundaries.
        drive(1, 1, 0, 8'd100, 28'h4000000);
        drive(1, 1, 1, 8'd100, 28'h0000400);
        drive(1, 1, 0, 8'd100, 28'hC000001);
        drive(1, 1, 0, 8'd254, 28'h8000000);
        drive(1, 1, 1, 8'd77,  28'h0000000);
        drive(1, 1, 0, 8'd10,  28'h0000400);
        drive(1, 1, 0, 8'd253, 28'h8000003);
        drive(1, 1, 0, 8'd1,   28'h4000000);
        drive(1, 1, 0, 8'd0,   28'h7FFFFFF);
        drive(1, 1, 1, 8'd16,  28'h0000400);
        drive(1, 1, 0, 8'd17,  28'h0000400);
        drive(1, 1, 0, 8'd200, 28'h0000001);
        idle(4);

        // Four back-to-back ops with a two-cycle stall in the middle.
        drive(1, 1, 0, 8'd120, 28'h0123456);
        drive(1, 1, 1, 8'd60,  28'h9ABCDEF);
        drive(1, 0, 0, 8'd33,  28'h0000055);
        drive(1, 0, 0, 8'd33,  28'h0000055);
        drive(1, 1, 0, 8'd90,  28'h2000000);
        drive(1, 1, 1, 8'd150, 28'h0000003);
        drive(0, 0, 0, 8'd0,   28'h0);
        drive(0, 0, 0, 8'd0,   28'h0);
        idle(5);

        // Clear with two ops in flight; nothing may emerge afterwards.
        drive(1, 1, 0, 8'd100, 28'h4000000);
        drive(1, 1, 0, 8'd101, 28'h4000000);
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0, '0);
            check("post_reset_idle", 64'(valid_out), 64'd0);
        end
        drive(1, 1, 1, 8'd50, 28'h0010000);
        idle(5);

        // Randomized traffic with random stalls.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 1) == 1, rand_exp(), rand_mant());
        end
        idle(6);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fp_add_v1_normalize_stage
